// File: rtl/playback_pkg.sv
// Shared types and constants for the keyboard-driven playback controller.
// Holds the ASCII key codes (upper case; the decoder folds lower case onto
// these), the playback state enum and the decoded command enum.
package playback_pkg;

  localparam logic [7:0] KeyPlay    = 8'h45;  // 'E'
  localparam logic [7:0] KeyPause   = 8'h44;  // 'D'
  localparam logic [7:0] KeyFwd     = 8'h46;  // 'F'
  localparam logic [7:0] KeyBwd     = 8'h42;  // 'B'
  localparam logic [7:0] KeyRestart = 8'h52;  // 'R'

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StPause
  } state_e;

  typedef enum logic [2:0] {
    CmdNone,
    CmdPlay,
    CmdPause,
    CmdFwd,
    CmdBwd,
    CmdRestart
  } cmd_e;

endpackage

// File: rtl/key_decoder.sv
// Combinational ASCII key decoder. Folds lower-case letters onto upper case
// and maps a valid key strobe to a playback command.
// Ports:
//   key_valid_i - key_code_i carries a new key this cycle
//   key_code_i  - ASCII code of the key
//   cmd_o       - decoded command, CmdNone when idle or key unrecognised
module key_decoder
  import playback_pkg::*;
(
  input  logic       key_valid_i,
  input  logic [7:0] key_code_i,
  output cmd_e       cmd_o
);

  logic [7:0] code_up;

  always_comb begin
    code_up = key_code_i;
    // Only fold real lower-case letters so non-letter codes never alias.
    if (key_code_i >= 8'h61 && key_code_i <= 8'h7A) begin
      code_up = key_code_i - 8'h20;
    end
    cmd_o = CmdNone;
    if (key_valid_i) begin
      case (code_up)
        KeyPlay:    cmd_o = CmdPlay;
        KeyPause:   cmd_o = CmdPause;
        KeyFwd:     cmd_o = CmdFwd;
        KeyBwd:     cmd_o = CmdBwd;
        KeyRestart: cmd_o = CmdRestart;
        default:    cmd_o = CmdNone;
      endcase
    end
  end

endmodule

// File: rtl/playback_ctrl_fsm.sv
// Keyboard-driven playback controller. Decodes key commands into
// play/pause/direction/restart and steps a sample address on each tick while
// playing, wrapping inside [START_ADDR, END_ADDR].
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   key_valid, key_code - one-cycle key strobe and ASCII code
//   tick                - sample-rate strobe
//   addr                - current sample address (registered)
//   addr_strobe         - pulse after every advance or restart reload
//   playing, forward    - in PLAY state / direction (1 = forward)
//   wrapped             - pulse with addr_strobe when the advance wrapped
module playback_ctrl_fsm
  import playback_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 'h7FFFF,
  parameter int unsigned STEP       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic              tick,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_strobe,
  output logic              playing,
  output logic              forward,
  output logic              wrapped
);

  // One extra bit so addr + STEP and START + STEP never overflow.
  localparam logic [ADDR_W:0] StartW = (ADDR_W+1)'(START_ADDR);
  localparam logic [ADDR_W:0] EndW   = (ADDR_W+1)'(END_ADDR);
  localparam logic [ADDR_W:0] StepW  = (ADDR_W+1)'(STEP);

  cmd_e              cmd;
  state_e            state_q, state_d;
  logic              fwd_q, fwd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              strobe_q, strobe_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W:0]   sum_fwd;

  key_decoder u_key_decoder (
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .cmd_o       (cmd)
  );

  assign addr_ext = {1'b0, addr_q};
  assign sum_fwd  = addr_ext + StepW;

  always_comb begin
    state_d  = state_q;
    fwd_d    = fwd_q;
    addr_d   = addr_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;

    case (cmd)
      CmdPlay:  state_d = StPlay;
      CmdPause: if (state_q == StPlay) state_d = StPause;
      CmdFwd:   fwd_d = 1'b1;
      CmdBwd:   fwd_d = 1'b0;
      default:  ;
    endcase

    // Restart beats a coincident tick; both use the pre-edge direction.
    if (cmd == CmdRestart) begin
      addr_d   = fwd_q ? StartW[ADDR_W-1:0] : EndW[ADDR_W-1:0];
      strobe_d = 1'b1;
    end else if (tick && state_q == StPlay) begin
      strobe_d = 1'b1;
      if (fwd_q) begin
        if (sum_fwd > EndW) begin
          addr_d = StartW[ADDR_W-1:0];
          wrap_d = 1'b1;
        end else begin
          addr_d = sum_fwd[ADDR_W-1:0];
        end
      end else begin
        if (addr_ext < StartW + StepW) begin
          addr_d = EndW[ADDR_W-1:0];
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q - StepW[ADDR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      fwd_q    <= 1'b1;
      addr_q   <= StartW[ADDR_W-1:0];
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fwd_q    <= fwd_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign addr        = addr_q;
  assign addr_strobe = strobe_q;
  assign playing     = (state_q == StPlay);
  assign forward     = fwd_q;
  assign wrapped     = wrap_q;

endmodule

// File: tb/tb_playback_ctrl_fsm.sv
module tb_playback_ctrl_fsm;

  localparam int AW = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       tick = 1'b0;

  logic [AW-1:0] o_addr   [2];
  logic          o_strobe [2];
  logic          o_play   [2];
  logic          o_fwd    [2];
  logic          o_wrap   [2];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Per-instance window parameters: instance 0 is 0..7 step 1, instance 1 is 0..10 step 3.
  int p_start [2] = '{0, 0};
  int p_end   [2] = '{7, 10};
  int p_step  [2] = '{1, 3};

  // Behavioural model: mode 0 idle, 1 play, 2 pause.
  int m_addr [2];
  int m_mode [2];
  bit m_fwd  [2];
  bit m_strb [2];
  bit m_wrap [2];

  always #5 clk = ~clk;

  playback_ctrl_fsm #(.ADDR_W(AW), .START_ADDR(0), .END_ADDR(7), .STEP(1)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .tick        (tick),
    .addr        (o_addr[0]),
    .addr_strobe (o_strobe[0]),
    .playing     (o_play[0]),
    .forward     (o_fwd[0]),
    .wrapped     (o_wrap[0])
  );

  playback_ctrl_fsm #(.ADDR_W(AW), .START_ADDR(0), .END_ADDR(10), .STEP(3)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .tick        (tick),
    .addr        (o_addr[1]),
    .addr_strobe (o_strobe[1]),
    .playing     (o_play[1]),
    .forward     (o_fwd[1]),
    .wrapped     (o_wrap[1])
  );

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    int c, na;
    bit ns, nw;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_addr[d] <= p_start[d];
        m_mode[d] <= 0;
        m_fwd[d]  <= 1'b1;
        m_strb[d] <= 1'b0;
        m_wrap[d] <= 1'b0;
      end
    end else begin
      c = int'(key_code);
      if (c >= "a" && c <= "z") c = c - 32;
      for (int d = 0; d < 2; d++) begin
        na = m_addr[d];
        ns = 1'b0;
        nw = 1'b0;
        if (key_valid && c == "R") begin
          na = m_fwd[d] ? p_start[d] : p_end[d];
          ns = 1'b1;
        end else if (tick && m_mode[d] == 1) begin
          ns = 1'b1;
          if (m_fwd[d]) begin
            if (m_addr[d] + p_step[d] > p_end[d]) begin na = p_start[d]; nw = 1'b1; end
            else na = m_addr[d] + p_step[d];
          end else begin
            if (m_addr[d] < p_start[d] + p_step[d]) begin na = p_end[d]; nw = 1'b1; end
            else na = m_addr[d] - p_step[d];
          end
        end
        m_addr[d] <= na;
        m_strb[d] <= ns;
        m_wrap[d] <= nw;
        if (key_valid) begin
          if (c == "E") m_mode[d] <= 1;
          else if (c == "D" && m_mode[d] == 1) m_mode[d] <= 2;
          else if (c == "F") m_fwd[d] <= 1'b1;
          else if (c == "B") m_fwd[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      for (int d = 0; d < 2; d++) begin
        ck($sformatf("model_addr[%0d]", d), 32'(o_addr[d]), 32'(m_addr[d]));
        ck($sformatf("model_strobe[%0d]", d), 32'(o_strobe[d]), 32'(m_strb[d]));
        ck($sformatf("model_playing[%0d]", d), 32'(o_play[d]), 32'(m_mode[d] == 1));
        ck($sformatf("model_forward[%0d]", d), 32'(o_fwd[d]), 32'(m_fwd[d]));
        ck($sformatf("model_wrapped[%0d]", d), 32'(o_wrap[d]), 32'(m_wrap[d]));
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic drive(input bit kv, input logic [7:0] kc, input bit tk);
    key_valid = kv;
    key_code  = kc;
    tick      = tk;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #4 reset = 1'b0;
  endtask

  logic [7:0] keys [14] = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h46, 8'h66, 8'h42, 8'h62,
                            8'h52, 8'h72, 8'h78, 8'h5A, 8'h05, 8'h20};

  initial begin
    #2 reset = 1'b1;
    #10 reset = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    ck("rst_addr", 32'(o_addr[0]), 0);
    ck("rst_playing", 32'(o_play[0]), 0);
    ck("rst_forward", 32'(o_fwd[0]), 1);
    ck("rst_strobe", 32'(o_strobe[0]), 0);
    ck("rst_wrapped", 32'(o_wrap[0]), 0);

    drive(1, "e", 0);
    ck("play_after_e", 32'(o_play[0]), 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 8'h00, 1);
      ck("fwd_addr", 32'(o_addr[0]), 32'(i));
      ck("fwd_strobe", 32'(o_strobe[0]), 1);
    end
    repeat (4) drive(0, 8'h00, 1);
    ck("reach_7", 32'(o_addr[0]), 7);
    drive(0, 8'h00, 1);
    ck("fwd_wrap_addr", 32'(o_addr[0]), 0);
    ck("fwd_wrap_flag", 32'(o_wrap[0]), 1);
    drive(1, "B", 0);
    ck("bwd_dir", 32'(o_fwd[0]), 0);
    drive(0, 8'h00, 1);
    ck("bwd_wrap_addr", 32'(o_addr[0]), 7);
    ck("bwd_wrap_flag", 32'(o_wrap[0]), 1);
    drive(0, 8'h00, 1);
    ck("bwd_step_addr", 32'(o_addr[0]), 6);
    ck("bwd_step_nowrap", 32'(o_wrap[0]), 0);

    drive(1, "F", 0);
    repeat (6) drive(0, 8'h00, 1);
    ck("at_4", 32'(o_addr[0]), 4);
    drive(1, "d", 1);
    ck("pause_tick_addr", 32'(o_addr[0]), 5);
    ck("pause_tick_playing", 32'(o_play[0]), 0);
    repeat (2) drive(0, 8'h00, 1);
    ck("paused_hold_addr", 32'(o_addr[0]), 5);
    ck("paused_no_strobe", 32'(o_strobe[0]), 0);
    drive(1, "E", 0);
    drive(0, 8'h00, 1);
    ck("resume_6", 32'(o_addr[0]), 6);
    drive(0, 8'h00, 1);
    ck("resume_7", 32'(o_addr[0]), 7);

    drive(1, "d", 0);
    drive(1, "b", 0);
    ck("pause_bwd_dir", 32'(o_fwd[0]), 0);
    drive(1, "r", 1);
    ck("restart_addr", 32'(o_addr[0]), 7);
    ck("restart_fwd", 32'(o_fwd[0]), 0);
    ck("restart_wrapped", 32'(o_wrap[0]), 0);
    ck("restart_strobe", 32'(o_strobe[0]), 1);
    ck("restart_paused", 32'(o_play[0]), 0);

    do_reset();
    drive(1, "E", 0);
    drive(0, 8'h00, 1);
    ck("step3_a", 32'(o_addr[1]), 3);
    drive(0, 8'h00, 1);
    ck("step3_b", 32'(o_addr[1]), 6);
    drive(0, 8'h00, 1);
    ck("step3_c", 32'(o_addr[1]), 9);
    drive(0, 8'h00, 1);
    ck("step3_wrap_addr", 32'(o_addr[1]), 0);
    ck("step3_wrap_flag", 32'(o_wrap[1]), 1);
    drive(1, "x", 0);
    ck("key_x_addr", 32'(o_addr[1]), 0);
    ck("key_x_playing", 32'(o_play[1]), 1);
    drive(1, "Z", 0);
    ck("key_Z_strobe", 32'(o_strobe[1]), 0);
    ck("key_Z_fwd", 32'(o_fwd[1]), 1);

    do_reset();
    drive(1, "e", 0);
    repeat (5) drive(0, 8'h00, 1);
    ck("pre_areset_addr", 32'(o_addr[0]), 5);
    #2 reset = 1'b1;
    #1;
    ck("areset_addr", 32'(o_addr[0]), 0);
    ck("areset_playing", 32'(o_play[0]), 0);
    ck("areset_forward", 32'(o_fwd[0]), 1);
    ck("areset_strobe", 32'(o_strobe[0]), 0);
    #3 reset = 1'b0;
    drive(0, 8'h00, 1);
    ck("post_reset_tick_addr", 32'(o_addr[0]), 0);
    ck("post_reset_tick_strobe", 32'(o_strobe[0]), 0);

    repeat (3000) begin
      bit kv;
      logic [7:0] kc;
      kv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) kc = 8'($urandom());
      else kc = keys[$urandom_range(0, 13)];
      drive(kv, kc, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/playback_ctrl_fsm.md
# playback_ctrl_fsm

Parametrised keyboard-driven playback controller for the flash audio player. Decodes ASCII key strobes from the PS/2 path (case-insensitive) into play/pause/direction/restart commands, and owns the sample address counter, which it steps at each sample tick, forwards or backwards, with wrap-around inside a configurable window. It sits between the keyboard receiver and the flash read FSM, replacing the bare direction-only control FSM.

## Interface
- `ADDR_W`, 23: width of the sample address.
- `START_ADDR`, 0: first address of the playback window.
- `END_ADDR`, 'h7FFFF: last address of the playback window, inclusive. `START_ADDR` <= `END_ADDR`.
- `STEP`, 1: address increment per tick. 1 <= `STEP` <= `END_ADDR` - `START_ADDR` + 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous active-high reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is a new key this cycle.
- `key_code` in 8: ASCII code of the key.
- `tick` in 1: sample-rate strobe, one cycle wide.
- `addr` out `ADDR_W`: current sample address, registered.
- `addr_strobe` out 1: one-cycle pulse when `addr` has just advanced or reloaded.
- `playing` out 1: high in PLAY.
- `forward` out 1: 1 = forward direction, 0 = backward.
- `wrapped` out 1: one-cycle pulse, coincident with `addr_strobe`, when the advance wrapped.

## Operation
- Commands are decoded from `key_code` when `key_valid` = 1. Upper and lower case are equivalent.
  - E/e ('h45/'h65): PLAY.
  - D/d ('h44/'h64): PAUSE.
  - F/f ('h46/'h66): FWD.
  - B/b ('h42/'h62): BWD.
  - R/r ('h52/'h72): RESTART.
  - Any other code is ignored, with no state or output change.
- States are IDLE, PLAY, and PAUSE. Direction is a separate register, independent of state.
- IDLE:
  - PLAY goes to PLAY.
  - FWD/BWD set the direction and stay in IDLE.
  - RESTART reloads the address and stays in IDLE.
  - PAUSE is ignored.
- PLAY:
  - PAUSE goes to PAUSE.
  - FWD/BWD change direction and keep playing.
  - RESTART reloads the address and keeps playing.
  - PLAY is a no-op.
- PAUSE:
  - PLAY goes to PLAY with the retained direction.
  - FWD/BWD change direction and stay paused.
  - RESTART reloads the address and stays paused.
  - PAUSE is a no-op.
- Restart reload value: `START_ADDR` if forward, `END_ADDR` if backward. The direction used is the one registered before this cycle.
- Advance: happens only when `tick` = 1 and the registered state is PLAY.
  - Forward: if `addr` > `END_ADDR` − `STEP`, load `START_ADDR` and pulse `wrapped`; else `addr` + `STEP`.
  - Backward: if `addr` < `START_ADDR` + `STEP`, load `END_ADDR` and pulse `wrapped`; else `addr` − `STEP`.
  - Compare in `ADDR_W`+1 bits so there is no overflow or underflow.
- Simultaneous events:
  - RESTART with `tick`: RESTART wins. The address reloads and `wrapped` stays 0.
  - PAUSE with `tick` in PLAY: the advance is applied; pause takes effect from the next cycle.
  - FWD/BWD with `tick`: the advance uses the old direction; the new direction applies from the next tick.
- `addr_strobe` pulses on every advance and every RESTART reload, including reloads in IDLE or PAUSE.

## Timing
- Reset values:
  - state IDLE.
  - `forward` = 1.
  - `addr` = `START_ADDR`.
  - `playing` = 0.
  - `addr_strobe` = 0.
  - `wrapped` = 0.
- Reset asserted mid-playback clears everything immediately and asynchronously. The first tick after release does not advance, because the state is IDLE.
- Latency of one cycle:
  - `key_valid` at edge N → `playing`/`forward` updated after edge N.
  - `tick` at edge N → `addr`, `addr_strobe`, and `wrapped` valid after edge N.
- No back-pressure. Ticks arriving while not in PLAY are dropped and not queued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `playback_pkg` holds:
  - Key code constants.
  - State enum {IDLE, PLAY, PAUSE}.
  - Command enum {CMD_NONE, CMD_PLAY, CMD_PAUSE, CMD_FWD, CMD_BWD, CMD_RESTART}.
- Sub-module `key_decoder`: purely combinational. Maps `key_valid`/`key_code` to a command and folds case. It is reusable by other keyboard consumers.
- The top holds the state register, the direction register, and the address datapath with wrap logic.

## Test plan
- Parameters `START_ADDR`=0, `END_ADDR`=7, `STEP`=1 unless noted.
- After reset, key 'e' then 3 ticks → `playing`=1, `addr` 0→1→2→3, 3 `addr_strobe` pulses.
- From `addr`=7 forward, tick → `addr`=0 and `wrapped`=1. Then 'B' and 2 ticks → 7, 6, with `wrapped` pulsing on the 0→7 step.
- PLAY at `addr`=4, 'd' coincident with tick → `addr`=5, then further ticks hold at 5. 'E' resumes 6, 7.
- 'b' in PAUSE, then 'r' coincident with tick → `addr`=7, `forward`=0, `wrapped`=0, still paused.
- `STEP`=3, `END_ADDR`=10 forward from 0 → 3, 6, 9, then 0 with `wrapped`=1. Keys 'x' and 'Z' → no change.
- Reset asserted between edges during PLAY at `addr`=5 → outputs return to reset values immediately. Post-release tick → `addr` stays 0.
